spi_slave: RTL and testbench

- SPI slave, the far end of the team's SPI master link, for boards where our SoC is the SPI target.
- Oversamples sclk, ss and mosi in the system clock domain and shifts full DATA_W-bit words LSB first.
- Exposes TX, RX and status registers on the same sel/we/address control interface as the master, with a one-cycle interrupt on word reception.

---
 rtl/spi_slave.sv | 213 +++++++++++++++++++++
 tb/tb_spi_slave.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// SPI target for boards where the SoC is the slave end of the SPI link.
// sclk, ss and mosi are oversampled in the clk domain (clk >= 8x sclk).
// Full DATA_W-bit words are shifted LSB first. The master drives mosi and
// samples miso on sclk falling edges. The slave samples mosi on sclk rising
// edges and advances miso on sclk falling edges.
//
// Register map (sel/we/address control port):
//   0 SLV_TX     : write loads tx_reg and clears tx_empty; read returns tx_reg
//   1 SLV_RX     : read returns rx_reg; the read clears rx_valid
//   2 SLV_STATUS : {busy, tx_empty, frame_err, overrun, rx_valid};
//                  a write of 1 to bit 1 or bit 2 clears overrun or frame_err
//   3 reserved   : reads 0, writes ignored
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   sclk, ss, mosi    SPI pins from the master, asynchronous to clk
//   miso              SPI data to the master
//   data_in/data_out  control write data / combinational read data
//   address, we, sel  control register select, write enable, access strobe
//   interrupt         one-clk pulse when a good word has been received
// -----------------------------------------------------------------------------
module spi_slave #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic [ADDR_W-1:0] address,
  input  logic              we,
  input  logic              sel,
  output logic              interrupt
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DONE
  } state_t;

  // Synchronisers. The third flop on sclk and ss gives edge detection.
  logic r_sclk_meta, r_sclk_s, r_sclk_d;
  logic r_ss_meta, r_ss_s, r_ss_d;
  logic r_mosi_meta, r_mosi_s;

  // Core state
  state_t            r_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              r_extra;      // rising edges seen after the counter saturated
  logic [DATA_W-1:0] r_rx_shift;
  logic [DATA_W-1:0] r_tx_shift;
  logic [DATA_W-1:0] r_tx_reg;
  logic [DATA_W-1:0] r_rx_reg;
  logic              r_rx_valid;
  logic              r_overrun;
  logic              r_frame_err;
  logic              r_tx_empty;
  logic              r_interrupt;

  logic w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;
  logic w_wr_tx, w_wr_status, w_rd_rx, w_frame_good;

  // The ss flops reset low so that a slave released from reset with ss
  // already low never sees a fall event and stays IDLE.
  // NOTE: every clocked process uses non-blocking (<=) assignments so all
  // flops sample the same pre-edge values; blocking here would create races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_meta <= 1'b0;
      r_sclk_s    <= 1'b0;
      r_sclk_d    <= 1'b0;
      r_ss_meta   <= 1'b0;
      r_ss_s      <= 1'b0;
      r_ss_d      <= 1'b0;
      r_mosi_meta <= 1'b0;
      r_mosi_s    <= 1'b0;
    end else begin
      r_sclk_meta <= sclk;
      r_sclk_s    <= r_sclk_meta;
      r_sclk_d    <= r_sclk_s;
      r_ss_meta   <= ss;
      r_ss_s      <= r_ss_meta;
      r_ss_d      <= r_ss_s;
      r_mosi_meta <= mosi;
      r_mosi_s    <= r_mosi_meta;
    end
  end

  assign w_sclk_rise = r_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~r_sclk_s & r_sclk_d;
  assign w_ss_fall   = ~r_ss_s & r_ss_d;
  assign w_ss_rise   = r_ss_s & ~r_ss_d;

  assign w_wr_tx     = sel & we & (address == ADDR_W'(0));
  assign w_wr_status = sel & we & (address == ADDR_W'(2));
  assign w_rd_rx     = sel & ~we & (address == ADDR_W'(1));

  assign w_frame_good = (r_bit_cnt == FULL_CNT) & ~r_extra;

  // FSM plus datapath. Register-port effects are written first; the FSM's
  // hardware sets come later in the block, so a set issued in the same clk
  // as a clear takes precedence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_extra     <= 1'b0;
      r_rx_shift  <= '0;
      r_tx_shift  <= '0;
      r_tx_reg    <= '0;
      r_rx_reg    <= '0;
      r_rx_valid  <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_tx_empty  <= 1'b0;
      r_interrupt <= 1'b0;
    end else begin
      r_interrupt <= 1'b0;

      if (w_wr_tx) begin
        r_tx_reg   <= data_in;
        r_tx_empty <= 1'b0;
      end
      if (w_rd_rx) begin
        r_rx_valid <= 1'b0;
      end
      if (w_wr_status) begin
        if (data_in[1]) r_overrun   <= 1'b0;
        if (data_in[2]) r_frame_err <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          // Keep the shifter primed so miso already shows bit 0 when ss falls.
          r_tx_shift <= r_tx_reg;
          if (w_ss_fall) begin
            r_state    <= ST_ACTIVE;
            r_bit_cnt  <= '0;
            r_extra    <= 1'b0;
            r_rx_shift <= '0;
          end
        end

        ST_ACTIVE: begin
          if (w_sclk_rise) begin
            if (r_bit_cnt == FULL_CNT) begin
              r_extra <= 1'b1;
            end else begin
              r_bit_cnt  <= r_bit_cnt + 1'b1;
              r_rx_shift <= {r_mosi_s, r_rx_shift[DATA_W-1:1]};
            end
          end
          if (w_sclk_fall) begin
            r_tx_shift <= {1'b0, r_tx_shift[DATA_W-1:1]};
          end
          if (w_ss_rise) begin
            r_state <= ST_DONE;
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          // A TX write landing in this clk holds fresh data, so it keeps
          // tx_empty low.
          if (!w_wr_tx) begin
            r_tx_empty <= 1'b1;
          end
          if (w_frame_good) begin
            r_rx_reg    <= r_rx_shift;
            r_rx_valid  <= 1'b1;
            r_interrupt <= 1'b1;
            // A read in this same clk has consumed the old word: no overrun.
            if (r_rx_valid && !w_rd_rx) begin
              r_overrun <= 1'b1;
            end
          end else begin
            r_frame_err <= 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign miso      = r_tx_shift[0];
  assign interrupt = r_interrupt;

  // NOTE: data_out gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    data_out = '0;
    case (address)
      ADDR_W'(0): data_out = r_tx_reg;
      ADDR_W'(1): data_out = r_rx_reg;
      ADDR_W'(2): data_out[4:0] = {(r_state != ST_IDLE), r_tx_empty,
                                   r_frame_err, r_overrun, r_rx_valid};
      default:    data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
//
// Bench for spi_slave. A bit-banged SPI master (sclk period = 10 clk) sends
// LSB-first words and collects miso on each falling edge. A table of
// full-frame vectors covers the main data path. Hand-written sequences
// cover overrun, short and long frames, reset mid-frame, a TX write during a
// frame, and an RX read in the same clk as frame completion.
// -----------------------------------------------------------------------------
module tb_spi_slave;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              sclk;
  logic              ss;
  logic              mosi;
  logic              miso;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic [ADDR_W-1:0] address;
  logic              we;
  logic              sel;
  logic              interrupt;

  int n_checks = 0;
  int n_err    = 0;
  int irq_cnt  = 0;
  int irq_base;

  logic [31:0] got;
  logic [31:0] rd;

  typedef struct {
    logic [31:0] tx_word;     // written to SLV_TX; master must receive it
    logic [31:0] mosi_word;   // sent by the master; SLV_RX must return it
    logic [31:0] exp_status;  // SLV_STATUS after the frame
  } vec_t;

  vec_t vecs[4];

  spi_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .ss        (ss),
    .mosi      (mosi),
    .miso      (miso),
    .data_in   (data_in),
    .data_out  (data_out),
    .address   (address),
    .we        (we),
    .sel       (sel),
    .interrupt (interrupt)
  );

  always #5 clk = ~clk;

  // The interrupt is one clk wide, so sampling it on negedges counts each
  // pulse exactly once.
  always @(negedge clk) begin
    if (interrupt === 1'b1) irq_cnt <= irq_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    sel     = 1'b1;
    we      = 1'b1;
    address = a;
    data_in = d;
    @(negedge clk);
    sel = 1'b0;
    we  = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    sel     = 1'b1;
    we      = 1'b0;
    address = a;
    #1 d = data_out;
    @(negedge clk);
    sel = 1'b0;
  endtask

  // Master side of one frame. All delays are multiples of the clk period,
  // so pin changes land on clk negedges. rst is pulsed just before bit
  // rst_bit (-1: never). Returns right as ss rises.
  task automatic send_bits(input logic [63:0] word, input int nbits,
                           input int rst_bit, output logic [31:0] rx);
    rx = '0;
    @(negedge clk);
    ss = 1'b0;
    #100;
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) begin
        rst = 1'b1;
        #30;
        rst = 1'b0;
      end
      mosi = word[i];
      #50 sclk = 1'b1;
      #50 sclk = 1'b0;
      if (i < 32) rx[i] = miso;
    end
    #50 ss = 1'b1;
  endtask

  task automatic run_frame(input logic [63:0] word, input int nbits,
                           input int rst_bit, output logic [31:0] rx);
    send_bits(word, nbits, rst_bit, rx);
    #200;
  endtask

  initial begin
    vecs[0] = '{32'hA5A5_0F0F, 32'h1234_5678, 32'h09};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h09};
    vecs[2] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h09};
    vecs[3] = '{32'h8000_0001, 32'h7FFF_FFFE, 32'h09};

    rst     = 1'b1;
    sclk    = 1'b0;
    ss      = 1'b1;
    mosi    = 1'b0;
    we      = 1'b0;
    sel     = 1'b0;
    address = '0;
    data_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // ---- reset state ----
    check("reset_miso", {31'd0, miso}, 32'd0);
    check("reset_interrupt", {31'd0, interrupt}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      reg_read(2'(a), rd);
      check($sformatf("reset_read_addr%0d", a), rd, 32'd0);
    end

    // ---- table-driven full frames ----
    for (int v = 0; v < 4; v++) begin
      reg_write(2'd0, vecs[v].tx_word);
      irq_base = irq_cnt;
      run_frame({32'd0, vecs[v].mosi_word}, 32, -1, got);
      check($sformatf("vec%0d_master_rx", v), got, vecs[v].tx_word);
      check($sformatf("vec%0d_irq_pulses", v), 32'(irq_cnt - irq_base), 32'd1);
      reg_read(2'd2, rd);
      check($sformatf("vec%0d_status", v), rd, vecs[v].exp_status);
      reg_read(2'd1, rd);
      check($sformatf("vec%0d_slv_rx", v), rd, vecs[v].mosi_word);
    end

    // ---- reserved address ----
    reg_write(2'd3, 32'hFFFF_FFFF);
    reg_read(2'd3, rd);
    check("reserved_read", rd, 32'd0);
    reg_read(2'd2, rd);
    check("reserved_write_status", rd, 32'h08);

    // ---- overrun; tx_empty frames resend the last tx_reg ----
    run_frame(64'h1, 32, -1, got);
    check("ovr_frame1_master_rx", got, 32'h8000_0001);
    run_frame(64'h2, 32, -1, got);
    check("ovr_frame2_master_rx", got, 32'h8000_0001);
    reg_read(2'd2, rd);
    check("ovr_status", rd, 32'h0B);
    reg_read(2'd1, rd);
    check("ovr_slv_rx", rd, 32'h2);
    reg_write(2'd2, 32'h2);
    reg_read(2'd2, rd);
    check("ovr_w1c_status", rd, 32'h08);

    // ---- short frame (10 bits) ----
    irq_base = irq_cnt;
    run_frame(64'h3FF, 10, -1, got);
    check("short_irq_pulses", 32'(irq_cnt - irq_base), 32'd0);
    reg_read(2'd2, rd);
    check("short_status", rd, 32'h0C);
    reg_read(2'd1, rd);
    check("short_slv_rx", rd, 32'h2);
    reg_write(2'd2, 32'h4);

    // ---- long frame (33 bits) ----
    irq_base = irq_cnt;
    run_frame(64'h1_1234_ABCD, 33, -1, got);
    check("long_irq_pulses", 32'(irq_cnt - irq_base), 32'd0);
    reg_read(2'd2, rd);
    check("long_status", rd, 32'h0C);
    reg_read(2'd1, rd);
    check("long_slv_rx", rd, 32'h2);
    reg_write(2'd2, 32'h4);

    // ---- good frame after the errors ----
    irq_base = irq_cnt;
    run_frame(64'hCAFE_F00D, 32, -1, got);
    check("recover_master_rx", got, 32'h8000_0001);
    check("recover_irq_pulses", 32'(irq_cnt - irq_base), 32'd1);
    reg_read(2'd2, rd);
    check("recover_status", rd, 32'h09);
    reg_read(2'd1, rd);
    check("recover_slv_rx", rd, 32'hCAFE_F00D);

    // ---- reset at bit 17, released while ss is still low ----
    reg_write(2'd0, 32'h1357_2468);
    irq_base = irq_cnt;
    run_frame(64'h0BAD_C0DE, 32, 17, got);
    check("rstmid_irq_pulses", 32'(irq_cnt - irq_base), 32'd0);
    reg_read(2'd2, rd);
    check("rstmid_status", rd, 32'h00);
    reg_read(2'd1, rd);
    check("rstmid_slv_rx", rd, 32'h0);
    run_frame(64'h0F0F_1234, 32, -1, got);
    check("rstmid_next_master_rx", got, 32'h0);
    reg_read(2'd2, rd);
    check("rstmid_next_status", rd, 32'h09);
    reg_read(2'd1, rd);
    check("rstmid_next_slv_rx", rd, 32'h0F0F_1234);

    // ---- TX write during ACTIVE only affects the next frame ----
    fork
      run_frame(64'h55AA_55AA, 32, -1, got);
      begin
        #1000;
        reg_write(2'd0, 32'hDEAD_BEEF);
      end
    join
    check("txmid_cur_master_rx", got, 32'h0);
    reg_read(2'd1, rd);
    check("txmid_cur_slv_rx", rd, 32'h55AA_55AA);
    run_frame(64'h1111_1111, 32, -1, got);
    check("txmid_next_master_rx", got, 32'hDEAD_BEEF);

    // ---- RX read in the same clk as DONE (rx_valid still set) ----
    // ss rises at T; the rise event shows at T+15..T+25, the FSM is in DONE
    // for the posedge at T+35, so the read strobe spans T+30..T+40.
    irq_base = irq_cnt;
    send_bits(64'h600D_F00D, 32, -1, got);
    #30;
    sel     = 1'b1;
    we      = 1'b0;
    address = 2'd1;
    #10;
    sel = 1'b0;
    #200;
    check("rddone_master_rx", got, 32'hDEAD_BEEF);
    check("rddone_irq_pulses", 32'(irq_cnt - irq_base), 32'd1);
    reg_read(2'd2, rd);
    check("rddone_status", rd, 32'h09);
    reg_read(2'd1, rd);
    check("rddone_slv_rx", rd, 32'h600D_F00D);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
